// File: rtl/pll_supervisor.sv
// PLL start-up supervisor: sequences PLL reset/lock qualification, retries on
// timeout, falls back to bypass on repeated failure, and generates tick enables.
module pll_supervisor #(
    parameter int RST_HOLD       = 3,
    parameter int LOCK_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 2,
    parameter int NUM_TICK       = 2,
    parameter int DIV_W          = 8
) (
    input  logic                      clock_in,
    input  logic                      reset_n,
    input  logic                      locked,
    input  logic [NUM_TICK*DIV_W-1:0] tick_div,
    output logic                      pll_resetb,
    output logic                      pll_bypass,
    output logic                      rst_out_n,
    output logic                      ready,
    output logic                      fault,
    output logic [1:0]                retry_cnt,
    output logic [7:0]                loss_cnt,
    output logic [NUM_TICK-1:0]       tick
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    state_t state, state_next;

    logic [1:0]        sync;
    logic              lock_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lock_qual, timeout;
    logic [1:0]        retry_inc;
    logic              resetb_d, bypass_d, rst_d, ready_d, fault_d;
    logic [DIV_W-1:0]  tick_cnt   [NUM_TICK];
    logic [DIV_W-1:0]  tick_cnt_d [NUM_TICK];
    logic [NUM_TICK-1:0] tick_d;

    assign lock_s = sync[1];

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], locked};
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state <= RESET_PLL;
        else          state <= state_next;
    end

    // Lock qualification is checked before timeout so a simultaneous lock wins.
    always_comb begin
        lock_qual  = (state == WAIT_LOCK) && lock_s && (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
        timeout    = (state == WAIT_LOCK) && !lock_qual && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
        retry_inc  = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
        state_next = state;
        case (state)
            RESET_PLL: if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_next = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_qual)    state_next = RUN;
                else if (timeout) state_next = (retry_inc == 2'(MAX_RETRIES)) ? FAULT : RESET_PLL;
            end
            RUN:       if (!lock_s) state_next = RESET_PLL;
            FAULT:     state_next = FAULT;
            default:   state_next = RESET_PLL;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the
    // same edge as the state and never see locked or tick_div combinationally.
    always_comb begin
        resetb_d = 1'b0;
        bypass_d = 1'b0;
        rst_d    = 1'b0;
        ready_d  = 1'b0;
        fault_d  = 1'b0;
        case (state_next)
            WAIT_LOCK: resetb_d = 1'b1;
            RUN: begin
                resetb_d = 1'b1;
                rst_d    = 1'b1;
                ready_d  = 1'b1;
            end
            FAULT: begin
                bypass_d = 1'b1;
                rst_d    = 1'b1;
                fault_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            pll_resetb <= 1'b0;
            pll_bypass <= 1'b0;
            rst_out_n  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            pll_resetb <= resetb_d;
            pll_bypass <= bypass_d;
            rst_out_n  <= rst_d;
            ready      <= ready_d;
            fault      <= fault_d;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt  <= '0;
            lock_cnt  <= '0;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            if (state_next != state) begin
                hold_cnt <= '0;
                lock_cnt <= '0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    RESET_PLL: hold_cnt <= hold_cnt + 1'b1;
                    WAIT_LOCK: begin
                        wait_cnt <= wait_cnt + 1'b1;
                        lock_cnt <= lock_s ? lock_cnt + 1'b1 : '0;
                    end
                    default: ;
                endcase
            end
            if (lock_qual)    retry_cnt <= '0;
            else if (timeout) retry_cnt <= retry_inc;
            if (state == RUN && !lock_s && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
        end
    end

    // The counter value shown alongside each registered tick is the one for the
    // upcoming cycle, so a divider change is applied at the very next edge.
    always_comb begin
        for (int unsigned i = 0; i < NUM_TICK; i++) begin
            tick_cnt_d[i] = '0;
            tick_d[i]     = 1'b0;
            if (ready_d) begin
                if (ready && !tick[i]) tick_cnt_d[i] = tick_cnt[i] + 1'b1;
                tick_d[i] = (tick_cnt_d[i] >= tick_div[i*DIV_W +: DIV_W]);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            tick <= '0;
            for (int unsigned i = 0; i < NUM_TICK; i++) tick_cnt[i] <= '0;
        end else begin
            tick <= tick_d;
            for (int unsigned i = 0; i < NUM_TICK; i++) tick_cnt[i] <= tick_cnt_d[i];
        end
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboarded bench for pll_supervisor: a cycle-level reference model queues the
// expected outputs after every edge and a monitor compares them against the DUT.
module tb_pll_supervisor;

    localparam int RST_HOLD = 3;
    localparam int LOCK_CYC = 4;
    localparam int TIMEOUT  = 16;
    localparam int MAXR     = 2;
    localparam int NT       = 2;
    localparam int DW       = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             locked = 1'b0;
    logic [NT*DW-1:0] tick_div = '0;
    logic             pll_resetb, pll_bypass, rst_out_n, ready, fault;
    logic [1:0]       retry_cnt;
    logic [7:0]       loss_cnt;
    logic [NT-1:0]    tick;

    pll_supervisor #(
        .RST_HOLD(RST_HOLD), .LOCK_CYCLES(LOCK_CYC), .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRIES(MAXR), .NUM_TICK(NT), .DIV_W(DW)
    ) dut (
        .clock_in(clk), .reset_n(rst_n), .locked(locked), .tick_div(tick_div),
        .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .rst_out_n(rst_out_n),
        .ready(ready), .fault(fault), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt),
        .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          resetb;
        logic          bypass;
        logic          rst;
        logic          rdy;
        logic          flt;
        logic [1:0]    retry;
        logic [7:0]    loss;
        logic [NT-1:0] tk;
    } obs_t;

    obs_t sb[$];
    event pushed;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase plus "cycles spent in phase" and "run of high samples".
    typedef enum {M_HOLD, M_WAIT, M_RUN, M_FAULT} mphase_t;
    mphase_t phase;
    int  age, highs, retries, losses;
    bit  pipe[$];
    int  since[NT];
    bit  tk[NT];

    function automatic obs_t expected_now();
        obs_t e;
        e = '0;
        e.retry = 2'(retries);
        e.loss  = 8'(losses);
        for (int c = 0; c < NT; c++) e.tk[c] = tk[c];
        case (phase)
            M_WAIT:  e.resetb = 1'b1;
            M_RUN:   begin e.resetb = 1'b1; e.rst = 1'b1; e.rdy = 1'b1; end
            M_FAULT: begin e.bypass = 1'b1; e.rst = 1'b1; e.flt = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        phase = M_HOLD; age = 0; highs = 0; retries = 0; losses = 0;
        pipe = {1'b0, 1'b0};
        for (int c = 0; c < NT; c++) begin since[c] = 0; tk[c] = 1'b0; end
    endtask

    task automatic model_step();
        bit ls, was_run;
        ls = pipe.pop_front();
        pipe.push_back(locked);
        was_run = (phase == M_RUN);
        case (phase)
            M_HOLD: begin
                age++;
                if (age == RST_HOLD) begin phase = M_WAIT; age = 0; highs = 0; end
            end
            M_WAIT: begin
                age++;
                highs = ls ? highs + 1 : 0;
                if (highs == LOCK_CYC) begin
                    phase = M_RUN; retries = 0;
                end else if (age == TIMEOUT) begin
                    retries = (retries < 3) ? retries + 1 : 3;
                    phase = (retries == MAXR) ? M_FAULT : M_HOLD;
                    age = 0;
                end
            end
            M_RUN: begin
                if (!ls) begin
                    losses = (losses < 255) ? losses + 1 : 255;
                    phase = M_HOLD; age = 0;
                end
            end
            default: ;
        endcase
        for (int c = 0; c < NT; c++) begin
            if (phase == M_RUN) begin
                since[c] = (was_run && !tk[c]) ? since[c] + 1 : 0;
                tk[c] = (since[c] >= int'(tick_div[c*DW +: DW]));
            end else begin
                since[c] = 0; tk[c] = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            sb.push_back(expected_now());
            -> pushed;
        end
    end

    initial begin
        obs_t e, a;
        forever begin
            @(pushed);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = {pll_resetb, pll_bypass, rst_out_n, ready, fault, retry_cnt, loss_cnt, tick};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got resetb=%b bypass=%b rst_out_n=%b ready=%b fault=%b retry=%0d loss=%0d tick=%b, expected resetb=%b bypass=%b rst_out_n=%b ready=%b fault=%b retry=%0d loss=%0d tick=%b",
                             $time, a.resetb, a.bypass, a.rst, a.rdy, a.flt, a.retry, a.loss, a.tk,
                             e.resetb, e.bypass, e.rst, e.rdy, e.flt, e.retry, e.loss, e.tk);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // which: 0 = ready, 1 = fault
    task automatic wait_for(input int which, input logic want, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if ((which == 0 ? ready : fault) === want) return;
            cyc(1);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: still %b after %0d cycles, required %b", name,
                 (which == 0 ? ready : fault), budget, want);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        tick_div = {DW'(4), DW'(0)};
        cyc(3);
        rst_n = 1'b1;

        // clean start, ticks 0/4, divider lowered at count 3, then a lock loss
        locked = 1'b1;
        wait_for(0, 1'b1, 100, "clean_start_ready");
        cyc(3);
        tick_div[DW +: DW] = DW'(1);
        cyc(12);
        tick_div[DW +: DW] = DW'(4);
        cyc(12);
        locked = 1'b0;
        cyc(1);
        locked = 1'b1;
        wait_for(0, 1'b0, 10, "loss_ready_fall");
        wait_for(0, 1'b1, 100, "relock_ready");
        cyc(5);

        // timeout path into sticky FAULT
        rst_n = 1'b0; locked = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        wait_for(1, 1'b1, 200, "timeout_fault");
        cyc(1000);
        check_val("fault_sticky", int'(fault), 1);
        check_val("fault_retry", int'(retry_cnt), MAXR);

        // glitching lock gives one timeout, then steady lock recovers
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            locked = (i % 4) != 3;
            cyc(1);
        end
        locked = 1'b1;
        wait_for(0, 1'b1, 100, "glitch_recover_ready");
        cyc(5);

        // 300 lock losses with randomized dividers
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NT; c++) tick_div[c*DW +: DW] = DW'($urandom_range(0, 6));
            wait_for(0, 1'b1, 100, "loss_loop_ready");
            cyc($urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) tick_div[DW +: DW] = DW'($urandom_range(0, 3));
            cyc($urandom_range(0, 4));
            locked = 1'b0;
            cyc(1);
            locked = 1'b1;
            wait_for(0, 1'b0, 10, "loss_loop_fall");
        end
        check_val("loss_saturated", int'(loss_cnt), 255);

        // asynchronous reset between edges while in RUN
        wait_for(0, 1'b1, 100, "pre_async_ready");
        cyc(4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        wait_for(0, 1'b1, 100, "async_restart_ready");
        cyc(10);

        cyc(2);
        check_val("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter RST_HOLD, default 3: number of clock_in cycles that pll_resetb is held low per PLL restart (at least 1).
REQ-002 Parameter LOCK_CYCLES, default 4: number of consecutive synchronised-high lock samples needed to qualify lock (at least 1).
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of WAIT_LOCK cycles per attempt (must be greater than LOCK_CYCLES).
REQ-004 Parameter MAX_RETRIES, default 2: number of consecutive timeouts that forces FAULT (at least 1).
REQ-005 Parameter NUM_TICK, default 2: number of tick channels; parameter DIV_W, default 8: width of each divider.
REQ-006 Port clock_in, input, 1 bit: the single clock, i.e. the raw reference oscillator, not the PLL output.
REQ-007 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port locked, input, 1 bit: PLL LOCK, asynchronous to clock_in.
REQ-009 Port tick_div, input, NUM_TICK*DIV_W bits: channel i uses bits [i*DIV_W +: DIV_W].
REQ-010 Port pll_resetb, output, 1 bit: drives the PLL RESETB pin, active low.
REQ-011 Port pll_bypass, output, 1 bit: drives the PLL BYPASS pin.
REQ-012 Port rst_out_n, output, 1 bit: system reset, active low, registered.
REQ-013 Port ready, output, 1 bit: high when the state is RUN.
REQ-014 Port fault, output, 1 bit: high when the state is FAULT.
REQ-015 Port retry_cnt, output, 2 bits: count of consecutive timeouts, saturating.
REQ-016 Port loss_cnt, output, 8 bits: count of lock losses seen in RUN, saturating at 255.
REQ-017 Port tick, output, NUM_TICK bits: one-cycle enable pulses, one per channel.

Function
REQ-018 locked shall pass through a 2-flop synchroniser; lock_s denotes the synchroniser output, delayed 2 cycles from locked.
REQ-019 States shall be RESET_PLL, WAIT_LOCK, RUN and FAULT, one-hot or binary.
REQ-020 RESET_PLL: pll_resetb=0 and rst_out_n=0; after exactly RST_HOLD cycles the block shall move to WAIT_LOCK, with the hold counter cleared on entry.
REQ-021 WAIT_LOCK: pll_resetb=1 and rst_out_n=0; the lock counter shall increment on lock_s=1, clear on lock_s=0, and the wait counter shall increment every cycle.
REQ-022 WAIT_LOCK exit to RUN: on the cycle the lock counter reaches LOCK_CYCLES, the next state shall be RUN and retry_cnt shall clear to 0.
REQ-023 WAIT_LOCK timeout: when the wait counter reaches TIMEOUT_CYCLES-1 without lock, retry_cnt shall increment; the next state shall be FAULT if the new value equals MAX_RETRIES, otherwise RESET_PLL.
REQ-024 If lock qualification and timeout occur in the same cycle, lock shall win: the block goes to RUN and retry_cnt does not increment.
REQ-025 RUN: rst_out_n=1 and ready=1, both first high in the first RUN cycle.
REQ-026 Lock loss: lock_s=0 in any RUN cycle shall clear rst_out_n and ready on the next edge, increment loss_cnt (saturating), and move the state to RESET_PLL.
REQ-027 FAULT: pll_bypass=1, pll_resetb=0, rst_out_n=1, fault=1 and ready=0; FAULT is sticky and exits only through reset_n.
REQ-028 Tick channel i: its counter shall clear and hold while ready=0.
REQ-029 Tick channel i: while ready=1, tick[i] shall pulse for one cycle when the counter is greater than or equal to the channel's divider value, and the counter shall then wrap to 0; the period is div+1 cycles.
REQ-030 Tick channel i with div=0: tick[i] shall be high on every RUN cycle.
REQ-031 Tick channel i: a change of tick_div shall take effect immediately; lowering it below the current count shall fire on the next cycle.
REQ-032 The first tick of channel i shall occur div cycles after RUN entry (counter starts at 0 in the first RUN cycle).
REQ-033 All outputs shall be driven from registers, with no combinational path from locked or tick_div to any output.

Reset
REQ-034 While reset_n=0, asynchronously: state=RESET_PLL, pll_resetb=0, pll_bypass=0, rst_out_n=0, ready=0, fault=0, retry_cnt=0, loss_cnt=0, tick=0, synchroniser flops=0, all counters=0.
REQ-035 reset_n asserted mid-operation, including in RUN or FAULT, shall abort immediately; after release the block restarts the full sequence from RESET_PLL.

Verification (defaults: RST_HOLD=3, LOCK_CYCLES=4, TIMEOUT=16, MAX_RETRIES=2)
REQ-036 Clean start: release reset_n, with locked=1 constantly -> pll_resetb low for cycles 1-3, lock_s high 2 cycles later, RUN reached and rst_out_n=1 at a deterministic cycle (about cycle 10), retry_cnt=0.
REQ-037 Timeout path: locked held at 0 -> two WAIT_LOCK windows of 16 cycles each, retry_cnt goes 1 then 2, FAULT entered, pll_bypass=1, fault=1, rst_out_n=1; state stays in FAULT for 1000 cycles.
REQ-038 Glitching lock: locked pattern 1,1,1,0 repeating -> lock counter never reaches 4, timeout fires and retry_cnt=1; then locked=1 steadily -> RUN reached and retry_cnt=0.
REQ-039 Lock loss: in RUN, drop locked for 1 cycle -> rst_out_n falls 3 cycles after the drop, loss_cnt=1, full restart; repeating this 300 times shall leave loss_cnt saturated at 255.
REQ-040 Ticks: div0=0 and div1=4 -> tick[0] high on every RUN cycle, tick[1] high every 5th cycle; changing div1 from 4 to 1 at count 3 -> tick on the next cycle, then period 2; lock loss -> ticks stop on the same edge ready falls.
REQ-041 Async reset during RUN: assert reset_n between clock edges -> all outputs reach their reset values before the next edge, and after release the same timing as the clean-start scenario repeats.
